button_event: RTL and testbench
===============================

# button_event

Converts the debounced level from a pushbutton conditioner into single-cycle user-interface events: press, release, short press, long press, and auto-repeat while held. It sits directly downstream of the pushbutton debounce stage, one instance per button. Its pulses feed menu, FSM, and counter logic, so that logic never does its own edge or hold timing.

## Interface
- `LONG_DELAY`, default 27000000: cycles from `press` to `long_press` (1 s at 27 MHz); legal ≥ 2.
- `REPEAT_DELAY`, default 6750000: cycles from `long_press` to the first `repeat`, and between successive `repeat`s (250 ms); legal ≥ 2.
- `REPEAT_EN`, default 1: 0 suppresses all `repeat` pulses.
- `NBITS`, default 25: hold-timer width; must hold max(`LONG_DELAY`, `REPEAT_DELAY`) − 1.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low (asserted at 0). Clears all state and outputs immediately.
- `clean` input 1: debounced button level, 1 = pressed; synchronous to `clk`.
- `press` output 1: one-cycle pulse on accepted press.
- `release` output 1: one-cycle pulse on release of an accepted press.
- `short_press` output 1: one-cycle pulse, coincident with `release`, when `long_press` never fired.
- `long_press` output 1: one-cycle pulse when the hold reaches `LONG_DELAY`.
- `repeat` output 1: one-cycle pulse at each repeat interval while held.
- `down` output 1: level; 1 while an accepted press is in progress.

## Operation
- All outputs are registered. Every output is 0 while `reset` is asserted and on its release.
- **WAIT_RELEASE** (reset state): no events. A button held through reset is ignored until it is released. `clean` = 0 → IDLE.
- **IDLE**: `clean` = 1 → PRESSED. Assert `press`, clear the timer, set `down`.
- **PRESSED**: timer increments each cycle.
  - `clean` = 0 → IDLE. Assert `release` and `short_press`, clear `down`.
  - Otherwise, when the hold reaches `LONG_DELAY` → HELD. Assert `long_press`, clear the timer.
- **HELD**: timer increments each cycle.
  - `clean` = 0 → IDLE. Assert `release` only (no `short_press`), clear `down`.
  - Otherwise, every `REPEAT_DELAY` cycles: assert `repeat` if `REPEAT_EN` = 1, clear the timer.
- **Priority**: release beats `long_press` and `repeat` in the same cycle. The losing pulse is dropped, not deferred.
- At most one of `press`, `long_press`, `repeat`, `release` is high in any cycle. `short_press` appears only alongside `release`.
- The timer never wraps: it is cleared on every state entry and at every threshold.

## Timing
- Latency: 1 cycle. If `clean` is first sampled 1 at edge k, `press` is high in the cycle after edge k and `down` rises at edge k.
- If `clean` is sampled 1 at edges k … k+N−1 and 0 at edge k+N, `release` is high in the cycle after edge k+N, i.e. N cycles after `press`.
- N < `LONG_DELAY`: `short_press` with `release`, no `long_press`.
- N = `LONG_DELAY`: collision. `release` and `short_press` fire; `long_press` is suppressed.
- N > `LONG_DELAY`: `long_press` at `press` + `LONG_DELAY`.
  - `repeat` at `press` + `LONG_DELAY` + m·`REPEAT_DELAY` (m ≥ 1), for each such time < N.
  - A `repeat` falling exactly at N is suppressed.
- Minimum gap between presses: 1 cycle of `clean` = 0 in IDLE is enough to re-arm.
- Async reset mid-press: outputs drop without a clock edge and state becomes WAIT_RELEASE. No `release` is generated.

## Structure
- Shared package `button_pkg`: the state encoding (WAIT_RELEASE, IDLE, PRESSED, HELD, 2 bits) and the default delay constants for 27 MHz. Other UI blocks reuse these.
- One sub-module, `hold_timer`: `NBITS` up-counter with synchronous clear, async active-low reset, and a terminal-count compare against a runtime limit (`LONG_DELAY` or `REPEAT_DELAY`, selected by the FSM).
- Top level: FSM, output registers, and one `hold_timer` instance.

## Test plan
All scenarios use `LONG_DELAY`=8, `REPEAT_DELAY`=4, `NBITS`=4 unless noted.
- **Held through reset:** `clean`=1 through reset release, 0 at cycle 5, 1 at cycle 10 → no events before cycle 10; `press` in the cycle after edge 10.
- **Short press:** `clean` high 3 cycles → `press`; 3 cycles later `release` + `short_press`; `long_press`/`repeat` never asserted; `down` high exactly 3 cycles.
- **Long hold:** `clean` high 18 cycles → `press` at t, `long_press` at t+8, `repeat` at t+12 and t+16, `release` at t+18 without `short_press`.
- **Collisions:**
  - Hold 8 cycles → `release` + `short_press` at t+8, no `long_press`.
  - Hold 20 cycles → `release` at t+20, no `repeat` at t+20.
- **Async reset:** assert `reset` mid-HELD between clock edges → all outputs 0 immediately; after deassert with `clean`=1, no events until `clean` goes 0 then 1.
- **REPEAT_EN=0:** hold 30 cycles → exactly one `press`, one `long_press` at t+8, one `release` at t+30, zero `repeat`.

Source files
------------

// File: rtl/button_pkg.sv
// Shared pushbutton UI definitions: event-FSM state encoding and default
// hold timings for a 27 MHz system clock.
package button_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_RELEASE = 2'd0,
        ST_IDLE         = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_HELD         = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_LONG_DELAY   = 27000000;  // 1 s
    localparam int unsigned DEFAULT_REPEAT_DELAY = 6750000;   // 250 ms
    localparam int          DEFAULT_NBITS        = 25;

    // True in the states where the hold timer is measuring an accepted press.
    function automatic logic is_holding(state_t s);
        return (s == ST_PRESSED) || (s == ST_HELD);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Hold-duration counter: counts up from zero each cycle, synchronous clear,
// and flags the cycle in which the count equals the selected terminal value.
module hold_timer #(
    parameter int NBITS = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [NBITS-1:0] last,
    output logic             tc
);

    logic [NBITS-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // last is the limit minus one, so tc lands on the edge that completes
    // exactly "limit" cycles after the clear.
    assign tc = (count == last);

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle press / release /
// short / long / repeat events plus a held level.
module button_event
    import button_pkg::*;
#(
    parameter int unsigned LONG_DELAY   = DEFAULT_LONG_DELAY,
    parameter int unsigned REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter bit          REPEAT_EN    = 1'b1,
    parameter int          NBITS        = DEFAULT_NBITS
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   clean,
    output logic   press,
    output logic   release_evt,
    output logic   short_press,
    output logic   long_press,
    output logic   repeat_evt,
    output logic   down,
    output state_t dbg_state
);

    localparam logic [NBITS-1:0] LONG_LAST   = NBITS'(LONG_DELAY - 1);
    localparam logic [NBITS-1:0] REPEAT_LAST = NBITS'(REPEAT_DELAY - 1);

    state_t           state;
    logic             timer_clear;
    logic             timer_tc;
    logic [NBITS-1:0] timer_last;

    // The timer restarts on every state change and every threshold, so it
    // can never wrap while a press is in progress.
    assign timer_last  = (state == ST_HELD) ? REPEAT_LAST : LONG_LAST;
    assign timer_clear = !is_holding(state) || !clean || timer_tc;

    hold_timer #(
        .NBITS (NBITS)
    ) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .last  (timer_last),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_WAIT_RELEASE;
            press       <= 1'b0;
            release_evt <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
            down        <= 1'b0;
        end else begin
            press       <= 1'b0;
            release_evt <= 1'b0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            repeat_evt  <= 1'b0;
            case (state)
                ST_WAIT_RELEASE: begin
                    if (!clean) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (clean) begin
                        state <= ST_PRESSED;
                        press <= 1'b1;
                        down  <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // Release is checked first so a coincident threshold is dropped.
                    if (!clean) begin
                        state       <= ST_IDLE;
                        release_evt <= 1'b1;
                        short_press <= 1'b1;
                        down        <= 1'b0;
                    end else if (timer_tc) begin
                        state      <= ST_HELD;
                        long_press <= 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!clean) begin
                        state       <= ST_IDLE;
                        release_evt <= 1'b1;
                        down        <= 1'b0;
                    end else if (timer_tc) begin
                        repeat_evt <= REPEAT_EN;
                    end
                end
                default: begin
                    state <= ST_WAIT_RELEASE;
                    down  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: two instances (repeat on / off) driven by the same
// button level and compared every cycle against a hold-length event model.
module tb_button_event;
    import button_pkg::*;

    localparam int L  = 8;
    localparam int R  = 4;
    localparam int NB = 4;

    logic   clk   = 1'b0;
    logic   reset = 1'b1;
    logic   clean = 1'b0;
    logic   a_press, a_release, a_short, a_long, a_repeat, a_down;
    logic   b_press, b_release, b_short, b_long, b_repeat, b_down;
    state_t a_dbg, b_dbg;

    always #5 clk = ~clk;

    button_event #(.LONG_DELAY(L), .REPEAT_DELAY(R), .REPEAT_EN(1'b1), .NBITS(NB)) dut_a (
        .clk(clk), .reset(reset), .clean(clean),
        .press(a_press), .release_evt(a_release), .short_press(a_short),
        .long_press(a_long), .repeat_evt(a_repeat), .down(a_down), .dbg_state(a_dbg)
    );

    button_event #(.LONG_DELAY(L), .REPEAT_DELAY(R), .REPEAT_EN(1'b0), .NBITS(NB)) dut_b (
        .clk(clk), .reset(reset), .clean(clean),
        .press(b_press), .release_evt(b_release), .short_press(b_short),
        .long_press(b_long), .repeat_evt(b_repeat), .down(b_down), .dbg_state(b_dbg)
    );

    // Expected vector layout: {down, press, release, short, long, repeat}
    logic [5:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // Model: armed once the button has been seen up since reset; m_n is the
    // number of edges since the accepted press.
    bit m_armed    = 1'b0;
    bit m_pressing = 1'b0;
    int m_n        = 0;

    function automatic logic [5:0] obs_a();
        return {a_down, a_press, a_release, a_short, a_long, a_repeat};
    endfunction

    function automatic logic [5:0] obs_b();
        return {b_down, b_press, b_release, b_short, b_long, b_repeat};
    endfunction

    task automatic model_reset();
        m_armed    = 1'b0;
        m_pressing = 1'b0;
        m_n        = 0;
    endtask

    // Apply one level, clock it in, and queue the expected outputs.
    task automatic drive_cycle(input logic c);
        logic p, rl, sh, lg, rp;
        p = 0; rl = 0; sh = 0; lg = 0; rp = 0;
        clean = c;
        @(posedge clk);
        #1;
        if (!m_armed) begin
            if (!c) m_armed = 1'b1;
        end else if (!m_pressing) begin
            if (c) begin
                m_pressing = 1'b1;
                m_n        = 0;
                p          = 1'b1;
            end
        end else begin
            m_n++;
            if (!c) begin
                rl         = 1'b1;
                sh         = (m_n <= L);
                m_pressing = 1'b0;
            end else begin
                lg = (m_n == L);
                rp = (m_n > L) && (((m_n - L) % R) == 0);
            end
        end
        exp_q.push_back({m_pressing, p, rl, sh, lg, rp});
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        clean = 1'b1;
        #2;
        vectors++;
        if ({obs_a(), obs_b()} !== 12'b0) begin
            miscompares++;
            $display("FAIL reset_async got a=%b b=%b exp 0", obs_a(), obs_b());
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({obs_a(), obs_b()} !== 12'b0 || a_dbg !== ST_WAIT_RELEASE || b_dbg !== ST_WAIT_RELEASE) begin
            miscompares++;
            $display("FAIL reset_hold got a=%b b=%b st=%0d/%0d exp 0 st=0", obs_a(), obs_b(), a_dbg, b_dbg);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_held_through_reset();
        logic pat[$];
        logic [5:0] e;
        int early = 0, p_at = -1;
        for (int i = 0; i < 5; i++) pat.push_back(1'b1);
        for (int i = 0; i < 5; i++) pat.push_back(1'b0);
        for (int i = 0; i < 4; i++) pat.push_back(1'b1);
        for (int i = 0; i < 2; i++) pat.push_back(1'b0);
        foreach (pat[i]) begin
            drive_cycle(pat[i]);
            e = exp_q.pop_front();
            vectors++;
            if ({obs_a(), obs_b()} !== {e, e[5:1], 1'b0}) begin
                miscompares++;
                $display("FAIL held_reset cyc=%0d got a=%b b=%b exp %b", i, obs_a(), obs_b(), e);
            end
            if (i < 10) early += a_press + a_release + a_long + a_repeat;
            if (a_press === 1'b1 && p_at < 0) p_at = i;
        end
        vectors++;
        if (early !== 0 || p_at !== 10) begin
            miscompares++;
            $display("FAIL held_reset_timing got early=%0d press_at=%0d exp 0/10", early, p_at);
        end
    endtask

    task automatic test_short_press();
        logic pat[$] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [5:0] e;
        int n_down = 0, n_lr = 0, n_short = 0, p_at = -1, r_at = -1;
        foreach (pat[i]) begin
            drive_cycle(pat[i]);
            e = exp_q.pop_front();
            vectors++;
            if ({obs_a(), obs_b()} !== {e, e[5:1], 1'b0}) begin
                miscompares++;
                $display("FAIL short_press cyc=%0d got a=%b b=%b exp %b", i, obs_a(), obs_b(), e);
            end
            n_down  += a_down;
            n_lr    += a_long + a_repeat;
            n_short += a_short;
            if (a_press === 1'b1) p_at = i;
            if (a_release === 1'b1) r_at = i;
        end
        vectors++;
        if (n_down !== 3 || n_lr !== 0 || n_short !== 1 || (r_at - p_at) !== 3) begin
            miscompares++;
            $display("FAIL short_press_counts got down=%0d lr=%0d short=%0d gap=%0d exp 3/0/1/3",
                     n_down, n_lr, n_short, r_at - p_at);
        end
    endtask

    // Hold for n cycles; checks event counts and the long/release offsets.
    task automatic test_long_hold(input int n, input int exp_rep_a);
        logic [5:0] e;
        int n_rep_a = 0, n_rep_b = 0, n_long = 0, n_short = 0, p_at = -1, l_at = -1, r_at = -1;
        int exp_long, exp_short;
        for (int i = 0; i < n + 4; i++) begin
            drive_cycle((i >= 2) && (i < n + 2));
            e = exp_q.pop_front();
            vectors++;
            if ({obs_a(), obs_b()} !== {e, e[5:1], 1'b0}) begin
                miscompares++;
                $display("FAIL hold_%0d cyc=%0d got a=%b b=%b exp %b", n, i, obs_a(), obs_b(), e);
            end
            n_rep_a += a_repeat;
            n_rep_b += b_repeat;
            n_long  += a_long;
            n_short += a_short;
            if (a_press === 1'b1) p_at = i;
            if (a_long === 1'b1) l_at = i;
            if (a_release === 1'b1) r_at = i;
        end
        exp_long  = (n > L) ? 1 : 0;
        exp_short = (n > L) ? 0 : 1;
        vectors++;
        if (n_rep_a !== exp_rep_a || n_rep_b !== 0 || n_long !== exp_long ||
            n_short !== exp_short || (r_at - p_at) !== n) begin
            miscompares++;
            $display("FAIL hold_%0d_counts got rep=%0d/%0d long=%0d short=%0d rel_off=%0d exp %0d/0/%0d/%0d/%0d",
                     n, n_rep_a, n_rep_b, n_long, n_short, r_at - p_at, exp_rep_a, exp_long, exp_short, n);
        end
        if (n > L) begin
            vectors++;
            if ((l_at - p_at) !== L) begin
                miscompares++;
                $display("FAIL hold_%0d_long_offset got %0d exp %0d", n, l_at - p_at, L);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] e;
        int events = 0, p_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            drive_cycle(i >= 2);
            e = exp_q.pop_front();
            vectors++;
            if ({obs_a(), obs_b()} !== {e, e[5:1], 1'b0}) begin
                miscompares++;
                $display("FAIL async_pre cyc=%0d got a=%b b=%b exp %b", i, obs_a(), obs_b(), e);
            end
        end
        #3 reset = 1'b0;
        #1;
        vectors++;
        if ({obs_a(), obs_b()} !== 12'b0 || a_dbg !== ST_WAIT_RELEASE) begin
            miscompares++;
            $display("FAIL async_reset got a=%b b=%b st=%0d exp 0 st=0", obs_a(), obs_b(), a_dbg);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(!(i == 5 || i == 9));
            e = exp_q.pop_front();
            vectors++;
            if ({obs_a(), obs_b()} !== {e, e[5:1], 1'b0}) begin
                miscompares++;
                $display("FAIL async_post cyc=%0d got a=%b b=%b exp %b", i, obs_a(), obs_b(), e);
            end
            if (i < 5) events += a_press + a_release + a_long + a_repeat + a_down;
            p_cnt += a_press;
        end
        vectors++;
        if (events !== 0 || p_cnt !== 1) begin
            miscompares++;
            $display("FAIL async_rearm got events=%0d presses=%0d exp 0/1", events, p_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        int p_cnt = 0, s_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            drive_cycle((i % 4) != 0);
            e = exp_q.pop_front();
            vectors++;
            if ({obs_a(), obs_b()} !== {e, e[5:1], 1'b0}) begin
                miscompares++;
                $display("FAIL back_to_back cyc=%0d got a=%b b=%b exp %b", i, obs_a(), obs_b(), e);
            end
            p_cnt += a_press;
            s_cnt += a_short;
        end
        vectors++;
        if (p_cnt !== 4 || s_cnt !== 4) begin
            miscompares++;
            $display("FAIL back_to_back_counts got press=%0d short=%0d exp 4/4", p_cnt, s_cnt);
        end
    endtask

    task automatic test_random();
        logic [5:0] e;
        int hold, gap;
        for (int k = 0; k < 40; k++) begin
            hold = $urandom_range(1, 26);
            gap  = $urandom_range(1, 3);
            for (int i = 0; i < hold + gap; i++) begin
                drive_cycle(i < hold);
                e = exp_q.pop_front();
                vectors++;
                if ({obs_a(), obs_b()} !== {e, e[5:1], 1'b0}) begin
                    miscompares++;
                    $display("FAIL random k=%0d hold=%0d cyc=%0d got a=%b b=%b exp %b",
                             k, hold, i, obs_a(), obs_b(), e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_held_through_reset();
        test_short_press();
        test_long_hold(18, 2);
        test_long_hold(8, 0);
        test_long_hold(20, 2);
        test_long_hold(30, 5);
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
